pkt_stream_arb: RTL and testbench

PKT_STREAM_ARB -- requirements
Module: pkt_stream_arb

---
 rtl/pkt_stream_arb.sv | 109 ++++++++++
 tb/tb_pkt_stream_arb.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pkt_stream_arb.sv
// pkt_stream_arb: round-robin packet arbiter serializing hdr, len, payload, crc onto one byte stream.
// Define PKT_STREAM_ARB_LEN_CLAMP_EN to clamp latched lengths above MAX_LEN.
module pkt_stream_arb #(
    parameter int NREQ    = 4,
    parameter int MAX_LEN = 16
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ-1:0]      vld_i,
    input  logic                 ovr_i,
    input  logic [NREQ-1:0][7:0] hdr_i,
    input  logic [NREQ-1:0][7:0] len_i,
    input  logic [NREQ-1:0][7:0] crc_i,
    input  logic [NREQ-1:0][7:0] pl_data_i,
    output logic [NREQ-1:0]      pl_rd_o,
    output logic [NREQ-1:0]      gnt_o,
    output logic [7:0]           out_data_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 out_sop_o,
    output logic                 out_eop_o,
    output logic                 done_o
);
    localparam int IW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || MAX_LEN < 1 || MAX_LEN > 255) begin : g_bad_param
        $error("pkt_stream_arb: parameter out of range");
    end

    typedef enum logic [2:0] {IDLE, HDR, LEN, PAY, CRC} state_t;

    state_t          state_q;
    logic [IW-1:0]   win_q, last_q, win_d;
    logic [7:0]      hdr_q, len_q, crc_q, cnt_q, len_d;
    logic [NREQ-1:0] gnt_q, elig;
    logic            done_q, any_d;

    // Highest-priority eligible requester is the first one after last_q; override beats the pointer.
    always_comb begin
        elig  = req_i & vld_i;
        any_d = |elig;
        win_d = '0;
        for (int k = NREQ; k >= 1; k--)
            if (elig[(int'(last_q) + k) % NREQ]) win_d = IW'((int'(last_q) + k) % NREQ);
        if (ovr_i && req_i[0]) begin
            win_d = '0;
            any_d = 1'b1;
        end
`ifdef PKT_STREAM_ARB_LEN_CLAMP_EN
        len_d = (len_i[win_d] > 8'(MAX_LEN)) ? 8'(MAX_LEN) : len_i[win_d];
`else
        len_d = len_i[win_d];
`endif
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            win_q   <= '0;
            last_q  <= IW'(NREQ - 1);
            hdr_q   <= '0;
            len_q   <= '0;
            crc_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= (state_q == CRC) && out_ready_i;
            case (state_q)
                IDLE: if (any_d) begin
                    win_q   <= win_d;
                    last_q  <= win_d;
                    hdr_q   <= hdr_i[win_d];
                    len_q   <= len_d;
                    crc_q   <= crc_i[win_d];
                    gnt_q   <= NREQ'(1) << win_d;
                    cnt_q   <= '0;
                    state_q <= HDR;
                end
                HDR: if (out_ready_i) state_q <= LEN;
                LEN: if (out_ready_i) state_q <= (len_q == 8'd0) ? CRC : PAY;
                PAY: if (out_ready_i) begin
                    cnt_q <= cnt_q + 8'd1;
                    if (cnt_q == len_q - 8'd1) begin
                        cnt_q   <= '0;
                        state_q <= CRC;
                    end
                end
                CRC: if (out_ready_i) begin
                    gnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid_o = state_q != IDLE;
    assign out_sop_o   = state_q == HDR;
    assign out_eop_o   = state_q == CRC;
    assign out_data_o  = (state_q == HDR) ? hdr_q :
                         (state_q == LEN) ? len_q :
                         (state_q == PAY) ? pl_data_i[win_q] :
                         (state_q == CRC) ? crc_q : 8'd0;
    assign pl_rd_o     = ((state_q == PAY) && out_ready_i) ? gnt_q : '0;
    assign gnt_o       = gnt_q;
    assign done_o      = done_q;
endmodule

// File: tb/tb_pkt_stream_arb.sv
// tb_pkt_stream_arb: directed checks of grant order, byte stream, stalls, override, length handling and reset abort.
module tb_pkt_stream_arb;
    localparam int NREQ = 4;
    localparam int MAX_LEN = 16;
`ifdef PKT_STREAM_ARB_LEN_CLAMP_EN
    localparam int LONG_EXP = 16;
`else
    localparam int LONG_EXP = 40;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, ovr, out_ready, out_valid, out_sop, out_eop, done;
    logic [NREQ-1:0] req, vld, pl_rd, gnt;
    logic [NREQ-1:0][7:0] hdr, len, crc, pl_data;
    logic [7:0] out_data;
    int pidx [NREQ];

    always_comb for (int i = 0; i < NREQ; i++) pl_data[i] = 8'(i * 64 + pidx[i]);

    pkt_stream_arb #(.NREQ(NREQ), .MAX_LEN(MAX_LEN)) dut (
        .clock_i(clk), .reset_i(rst), .req_i(req), .vld_i(vld), .ovr_i(ovr),
        .hdr_i(hdr), .len_i(len), .crc_i(crc), .pl_data_i(pl_data), .pl_rd_o(pl_rd),
        .gnt_o(gnt), .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_sop_o(out_sop), .out_eop_o(out_eop), .done_o(done)
    );

    int nchk = 0, npass = 0;
    logic [7:0] bq [$];
    bit sq [$], eq [$];
    int nrd, fv, ncyc;
    bit dn;
    logic [NREQ-1:0] g;
    logic [3:0] pat = 4'b1001;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = '0; vld = '0; ovr = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) pidx[i] = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_req();
        req = '0; vld = '0; ovr = 1'b0;
    endtask

    task automatic collect(input bit stall);
        logic [7:0] pd;
        logic ps, pe;
        bit hp;
        logic [NREQ-1:0] rd;
        bq.delete(); sq.delete(); eq.delete();
        nrd = 0; fv = -1; dn = 0; g = '0; hp = 0; ncyc = 0; pd = '0; ps = 0; pe = 0;
        for (int c = 0; c < 400 && !dn; c++) begin
            @(negedge clk);
            out_ready = stall ? pat[c % 4] : 1'b1;
            #1;
            if (hp) begin
                chk("stall_data", out_data, pd);
                chk("stall_sop", out_sop, ps);
                chk("stall_eop", out_eop, pe);
                hp = 0;
            end
            if (out_valid) begin
                if (fv < 0) begin fv = c; g = gnt; end
                if (out_ready) begin
                    bq.push_back(out_data); sq.push_back(out_sop); eq.push_back(out_eop);
                end else begin
                    hp = 1; pd = out_data; ps = out_sop; pe = out_eop;
                end
            end
            if (fv >= 0) ncyc++;
            rd = pl_rd;
            if (rd != '0) nrd++;
            if (done) begin
                dn = 1;
                chk("gnt_clr", gnt, '0);
            end else begin
                @(posedge clk); #1;
                for (int i = 0; i < NREQ; i++) if (rd[i]) pidx[i]++;
            end
        end
        out_ready = 1'b1;
    endtask

    task automatic check_pkt(input logic [NREQ-1:0] eg, input logic [7:0] h, input logic [7:0] l,
                             input logic [7:0] cr, input int np, input int base);
        int ns, ne;
        chk("done_seen", dn, 1);
        chk("gnt", g, eg);
        chk("nbytes", bq.size(), np + 3);
        chk("pl_rd_cnt", nrd, np);
        if (bq.size() == np + 3) begin
            chk("hdr", bq[0], h);
            chk("len", bq[1], l);
            for (int k = 0; k < np; k++) chk("pay", bq[2 + k], 8'(base + k));
            chk("crc", bq[np + 2], cr);
            ns = 0; ne = 0;
            foreach (sq[k]) begin ns += int'(sq[k]); ne += int'(eq[k]); end
            chk("sop_first", sq[0], 1);
            chk("eop_last", eq[np + 2], 1);
            chk("sop_cnt", ns, 1);
            chk("eop_cnt", ne, 1);
        end
    endtask

    initial begin
        rst = 1'b1; req = '0; vld = '0; ovr = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            pidx[i] = 0; hdr[i] = 8'(8'hA0 + i); len[i] = 8'd0; crc[i] = 8'(8'hC0 + i);
        end
        // reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_pl_rd", pl_rd, 0);
        chk("rst_sop", out_sop, 0);
        chk("rst_eop", out_eop, 0);
        chk("rst_done", done, 0);
        chk("rst_data", out_data, 0);
        do_reset();

        // single packet from requester 1
        len[1] = 8'd3; req = 4'b0010; vld = 4'b0010;
        collect(0);
        clear_req();
        check_pkt(4'b0010, 8'hA1, 8'd3, 8'hC1, 3, 64);

        // back-to-back round robin with len 0
        do_reset();
        len = '0; req = 4'b1111; vld = 4'b1111;
        for (int p = 0; p < 5; p++) begin
            collect(0);
            if (p == 4) clear_req();
            check_pkt(NREQ'(1) << (p % 4), 8'(8'hA0 + p % 4), 8'd0, 8'(8'hC0 + p % 4), 0, 0);
            chk("pkt_cycles", ncyc, 4);
            if (p > 0) chk("gap_one_idle", fv, 0);
        end

        // override vs pointer
        do_reset();
        req = 4'b0100; vld = 4'b0100;
        collect(0); clear_req();
        chk("set_last2", g, 4'b0100);
        req = 4'b1101; vld = 4'b1100; ovr = 1'b1;
        collect(0); clear_req();
        chk("ovr_win0", g, 4'b0001);
        req = 4'b0100; vld = 4'b0100;
        collect(0); clear_req();
        chk("set_last2b", g, 4'b0100);
        req = 4'b1101; vld = 4'b1100; ovr = 1'b0;
        collect(0); clear_req();
        chk("rr_win3", g, 4'b1000);
        req = 4'b1010; vld = 4'b1010; ovr = 1'b1;
        collect(0); clear_req();
        chk("ovr_noreq0", g, 4'b0010);

        // stalls
        do_reset();
        len[0] = 8'd2; req = 4'b0001; vld = 4'b0001;
        collect(1); clear_req();
        check_pkt(4'b0001, 8'hA0, 8'd2, 8'hC0, 2, 0);

        // long length
        do_reset();
        len[0] = 8'd40; req = 4'b0001; vld = 4'b0001;
        collect(0); clear_req();
        check_pkt(4'b0001, 8'hA0, 8'(LONG_EXP), 8'hC0, LONG_EXP, 0);

        // reset during payload
        do_reset();
        len = '0; len[0] = 8'd5; req = 4'b0001; vld = 4'b0001;
        begin
            int rc;
            rc = 0;
            for (int c = 0; c < 20 && rc < 2; c++) begin
                @(negedge clk); #1;
                if (pl_rd[0]) rc++;
                if (rc < 2) begin @(posedge clk); #1; if (pl_rd[0]) pidx[0]++; end
            end
            chk("reach_pay1", rc, 2);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_valid", out_valid, 0);
        chk("abort_gnt", gnt, 0);
        chk("abort_pl_rd", pl_rd, 0);
        chk("abort_sop_eop", {out_sop, out_eop}, 0);
        chk("abort_data", out_data, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        rst = 1'b0; clear_req();
        @(negedge clk); #1;
        chk("post_abort_done", done, 0);
        len = '0; req = 4'b1111; vld = 4'b1111;
        collect(0); clear_req();
        chk("post_abort_prio", g, 4'b0001);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
